// File: rtl/dp_ctrl_fsm.sv
// Fetch/decode/execute/writeback controller for the ARM data-processing datapath.
// Define DP_COND_EXEC_EN to evaluate the condition field against NZCV.
module dp_ctrl_fsm (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        run_in,
    output logic        mem_req_out,
    input  logic        mem_ack_in,
    input  logic [31:0] mem_rdata_in,
    output logic        pc_inc_out,
    input  logic [3:0]  flags_in,
    output logic [3:0]  rf_rn_addr_out,
    output logic [3:0]  rf_rm_addr_out,
    output logic [3:0]  rf_wa_out,
    output logic [11:0] imm12_out,
    output logic        alu_src_imm_out,
    output logic [3:0]  alu_ctrl_out,
    output logic        alu_res_we_out,
    output logic        rf_we_out,
    output logic        flags_we_out,
    output logic        illegal_out,
    output logic        busy_out,
    output logic [31:0] instr_count_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] ir;
    logic [31:0] retired;

    logic [3:0] opcode;
    logic       is_test;
    logic       legal;
    logic       cond_pass;
    logic       in_dp;

    assign opcode  = ir[24:21];
    assign is_test = (opcode[3:2] == 2'b10);
    assign in_dp   = (state == S_DECODE) || (state == S_EXEC) || (state == S_WB);

    always_comb begin
        legal = (ir[27:26] == 2'b00);
        if (!ir[25] && (ir[11:4] != 8'h00))
            legal = 1'b0;
        if (is_test && !ir[20])
            legal = 1'b0;
        if (!is_test && (ir[15:12] == 4'hf))
            legal = 1'b0;
    end

`ifdef DP_COND_EXEC_EN
    logic n_f, z_f, c_f, v_f;
    assign {n_f, z_f, c_f, v_f} = flags_in;

    always_comb begin
        cond_pass = 1'b0;
        unique case (ir[31:28])
            4'h0: cond_pass = z_f;
            4'h1: cond_pass = !z_f;
            4'h2: cond_pass = c_f;
            4'h3: cond_pass = !c_f;
            4'h4: cond_pass = n_f;
            4'h5: cond_pass = !n_f;
            4'h6: cond_pass = v_f;
            4'h7: cond_pass = !v_f;
            4'h8: cond_pass = c_f && !z_f;
            4'h9: cond_pass = !c_f || z_f;
            4'ha: cond_pass = (n_f == v_f);
            4'hb: cond_pass = (n_f != v_f);
            4'hc: cond_pass = !z_f && (n_f == v_f);
            4'hd: cond_pass = z_f || (n_f != v_f);
            4'he: cond_pass = 1'b1;
            4'hf: cond_pass = 1'b0;
        endcase
    end
`else
    logic unused_cond;
    assign unused_cond = ^{ir[31:28], flags_in};
    assign cond_pass   = 1'b1;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= S_IDLE;
            ir      <= '0;
            retired <= '0;
        end else begin
            state <= next_state;
            if ((state == S_FETCH) && mem_ack_in)
                ir <= mem_rdata_in;
            if (state == S_WB)
                retired <= retired + 32'd1;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:
                if (run_in)
                    next_state = S_FETCH;
            S_FETCH:
                if (mem_ack_in)
                    next_state = S_DECODE;
            S_DECODE:
                if (legal && cond_pass)
                    next_state = S_EXEC;
                else
                    next_state = run_in ? S_FETCH : S_IDLE;
            S_EXEC:
                next_state = S_WB;
            S_WB:
                next_state = run_in ? S_FETCH : S_IDLE;
            default:
                next_state = S_IDLE;
        endcase
    end

    // Operand fields are only presented while an instruction is in flight.
    always_comb begin
        mem_req_out     = 1'b0;
        pc_inc_out      = 1'b0;
        alu_src_imm_out = 1'b0;
        alu_res_we_out  = 1'b0;
        rf_we_out       = 1'b0;
        flags_we_out    = 1'b0;
        illegal_out     = 1'b0;
        rf_rn_addr_out  = in_dp ? ir[19:16] : 4'h0;
        rf_rm_addr_out  = in_dp ? ir[3:0]   : 4'h0;
        rf_wa_out       = in_dp ? ir[15:12] : 4'h0;
        imm12_out       = in_dp ? ir[11:0]  : 12'h000;
        alu_ctrl_out    = in_dp ? opcode    : 4'h0;
        unique case (state)
            S_FETCH: begin
                mem_req_out = 1'b1;
                pc_inc_out  = mem_ack_in;
            end
            S_DECODE:
                illegal_out = !legal;
            S_EXEC: begin
                alu_src_imm_out = ir[25];
                alu_res_we_out  = 1'b1;
            end
            S_WB: begin
                rf_we_out    = !is_test;
                flags_we_out = ir[20];
            end
            default: ;
        endcase
    end

    assign busy_out        = (state != S_IDLE);
    assign instr_count_out = retired;

endmodule
